// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative signed
// multiply and restoring divide (one bit per cycle), sign fix-up in FIX.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_AND = 4'd0,  OP_OR   = 4'd1,  OP_ADD = 4'd2,
                         OP_SUB = 4'd3,  OP_NEG  = 4'd4,  OP_NOT = 4'd5,
                         OP_SHR = 4'd6,  OP_SHRA = 4'd7,  OP_SHL = 4'd8,
                         OP_ROR = 4'd9,  OP_ROL  = 4'd10, OP_MUL = 4'd11,
                         OP_DIV = 4'd12;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  // operation context latched on the accepting edge
  logic             is_mul;   // 1: MUL, 0: DIV (only meaningful in CALC/FIX)
  logic             sa, sb;   // operand signs
  logic             b_zero;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] md;       // MUL: |a| multiplicand; DIV: |b| divisor
  logic [WIDTH-1:0] hi_r;     // MUL: partial product high; DIV: remainder
  logic [WIDTH-1:0] lo_r;     // MUL: multiplier / product low; DIV: quotient
  logic [SHW-1:0]   cnt;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] single_lo;
  logic [2*WIDTH-1:0] dbl;
  logic [SHW-1:0]   sh;
  logic             is_iter, is_illegal;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] div_r_n, div_q_n;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign abs_a      = a[WIDTH-1] ? -a : a;
  assign abs_b      = b[WIDTH-1] ? -b : b;
  assign is_iter    = (op == OP_MUL) || (op == OP_DIV);
  assign is_illegal = (op > OP_DIV);

  // single-cycle datapath straight from the ports
  always_comb begin
    single_lo = '0;
    sh        = b[SHW-1:0];
    dbl       = {a, a};
    case (op)
      OP_AND:  single_lo = a & b;
      OP_OR:   single_lo = a | b;
      OP_ADD:  single_lo = a + b;
      OP_SUB:  single_lo = a - b;
      OP_NEG:  single_lo = -b;
      OP_NOT:  single_lo = ~b;
      OP_SHR:  single_lo = a >> sh;
      OP_SHRA: single_lo = $unsigned($signed(a) >>> sh);
      OP_SHL:  single_lo = a << sh;
      OP_ROR:  single_lo = WIDTH'(dbl >> sh);
      OP_ROL:  single_lo = WIDTH'((dbl << sh) >> WIDTH);
      default: single_lo = '0;
    endcase
  end

  // one iteration of shift-add multiply and restoring divide on magnitudes
  always_comb begin
    mul_sum  = lo_r[0] ? ({1'b0, hi_r} + {1'b0, md}) : {1'b0, hi_r};
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_r[WIDTH-1:1]};
    // remainder stays below |b| <= 2^(WIDTH-1), so its top bit is free
    rem_sh   = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {1'b0, md};
    if (!diff[WIDTH]) begin
      div_r_n = diff[WIDTH-1:0];
      div_q_n = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_r_n = rem_sh;
      div_q_n = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // sign restoration applied in FIX
  always_comb begin
    prod_fix = (sa ^ sb) ? -{hi_r, lo_r} : {hi_r, lo_r};
    quo_fix  = (sa ^ sb) ? -lo_r : lo_r;
    rem_fix  = sa ? -hi_r : hi_r;
  end

  // state register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = is_iter ? CALC : DONE;
      CALC: if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      is_mul     <= 1'b0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      b_zero     <= 1'b0;
      a_l        <= '0;
      md         <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      cnt        <= '0;
      result_lo  <= '0;
      result_hi  <= '0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (is_iter) begin
            is_mul <= (op == OP_MUL);
            sa     <= a[WIDTH-1];
            sb     <= b[WIDTH-1];
            b_zero <= (b == '0);
            a_l    <= a;
            hi_r   <= '0;
            cnt    <= '0;
            md     <= (op == OP_MUL) ? abs_a : abs_b;
            lo_r   <= (op == OP_MUL) ? abs_b : abs_a;
          end else begin
            result_lo  <= single_lo;
            result_hi  <= '0;
            div_zero   <= 1'b0;
            illegal_op <= is_illegal;
          end
        end
        CALC: begin
          cnt  <= cnt + 1'b1;
          hi_r <= is_mul ? mul_hi_n : div_r_n;
          lo_r <= is_mul ? mul_lo_n : div_q_n;
        end
        FIX: begin
          illegal_op <= 1'b0;
          if (is_mul) begin
            result_lo <= prod_fix[WIDTH-1:0];
            result_hi <= prod_fix[2*WIDTH-1:WIDTH];
            div_zero  <= 1'b0;
          end else if (b_zero) begin
            result_lo <= '1;
            result_hi <= a_l;
            div_zero  <= 1'b1;
          end else begin
            result_lo <= quo_fix;
            result_hi <= rem_fix;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed table, random ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_seq_alu;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero, illegal_op;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_zero(div_zero), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        dz, il;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: plain arithmetic on the opcode definitions
  function automatic vec_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    longint sx, sy, p;
    int sh;
    sh = int'(y[4:0]);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    v.op = o; v.a = x; v.b = y; v.lo = '0; v.hi = '0; v.dz = 0; v.il = 0; v.lat = 1;
    case (o)
      4'd0:  v.lo = x & y;
      4'd1:  v.lo = x | y;
      4'd2:  v.lo = x + y;
      4'd3:  v.lo = x - y;
      4'd4:  v.lo = 32'd0 - y;
      4'd5:  v.lo = ~y;
      4'd6:  v.lo = x >> sh;
      4'd7:  v.lo = $unsigned($signed(x) >>> sh);
      4'd8:  v.lo = x << sh;
      4'd9:  v.lo = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      4'd10: v.lo = (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
      4'd11: begin
        p = sx * sy;
        v.lo = p[31:0]; v.hi = p[63:32]; v.lat = 34;
      end
      4'd12: begin
        v.lat = 34;
        if (y == 0) begin
          v.lo = 32'hFFFF_FFFF; v.hi = x; v.dz = 1;
        end else begin
          p = sx / sy; v.lo = p[31:0];
          p = sx % sy; v.hi = p[31:0];
        end
      end
      default: v.il = 1;
    endcase
    return v;
  endfunction

  // issue one op from IDLE, scramble inputs after acceptance, wait for done
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    op = o; a = x; b = y; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
      end
    end while (!done && lat < 100);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    logic [31:0] lo_seen;
    run_op(v.op, v.a, v.b, lat);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " lo"}, 64'(result_lo), 64'(v.lo));
    check({tag, " hi"}, 64'(result_hi), 64'(v.hi));
    check({tag, " div_zero"}, 64'(div_zero), 64'(v.dz));
    check({tag, " illegal"}, 64'(illegal_op), 64'(v.il));
    lo_seen = result_lo;
    @(negedge clock);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " hold_lo"}, 64'(result_lo), 64'(lo_seen));
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] lo, input logic [31:0] hi,
                              input logic dz, input logic il, input int lat);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.lo = lo; v.hi = hi; v.dz = dz; v.il = il; v.lat = lat;
    return v;
  endfunction

  initial begin
    int lat, seen;
    vec_t v;

    // expected values written out by hand
    tbl.push_back(mk(4'd2,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd11, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0, 34));
    tbl.push_back(mk(4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 34));
    tbl.push_back(mk(4'd12, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1, 0, 34));
    tbl.push_back(mk(4'd9,  32'h0000_0001, 32'h21,        32'h8000_0000, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd14, 32'h1234_5678, 32'h9,         32'h0,         32'h0,         0, 1, 1));
    tbl.push_back(mk(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         0, 0, 34));
    tbl.push_back(mk(4'd12, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0, 0, 34));
    tbl.push_back(mk(4'd11, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 0, 0, 34));
    tbl.push_back(mk(4'd3,  32'd0,         32'd1,         32'hFFFF_FFFF, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd4,  32'hDEAD_BEEF, 32'd5,         32'hFFFF_FFFB, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd5,  32'h1,         32'h0,         32'hFFFF_FFFF, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd8,  32'h1,         32'd31,        32'h8000_0000, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd6,  32'h8000_0000, 32'h20,        32'h8000_0000, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd10, 32'h8000_0001, 32'd1,         32'h0000_0003, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0,         0, 0, 1));
    tbl.push_back(mk(4'd1,  32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0, 32'h0,         0, 0, 1));

    // reset state, with start asserted during clear
    clear = 1'b1; start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
    repeat (3) @(negedge clock);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset lo", 64'(result_lo), 64'd0);
    check("reset hi", 64'(result_hi), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset illegal", 64'(illegal_op), 64'd0);
    clear = 1'b0; start = 1'b0;

    // directed table
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  o;
      logic [31:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
      v = model(o, x, y);
      apply(v, $sformatf("rnd%0d op%0d", i, o));
    end

    // clear in the middle of a MUL: abort, no done, outputs zeroed
    @(negedge clock);
    op = 4'd11; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1; start = 1'b1; op = 4'd2;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort lo", 64'(result_lo), 64'd0);
    check("abort hi", 64'(result_hi), 64'd0);
    @(negedge clock);
    clear = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);
    run_op(4'd2, 32'd2, 32'd3, lat);
    check("post-abort add lo", 64'(result_lo), 64'd5);
    check("post-abort add lat", 64'(lat), 64'd1);

    // start held high through a DIV with a different op: ignored;
    // then op=14 accepted right after done
    @(negedge clock);
    while (busy) @(negedge clock);
    op = 4'd12; a = 32'd100; b = 32'd7; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin op = 4'd2; a = 32'd1; b = 32'd1; end
    end while (!done && lat < 100);
    check("held div lat", 64'(lat), 64'd34);
    check("held div lo", 64'(result_lo), 64'd14);
    check("held div hi", 64'(result_hi), 64'd2);
    op = 4'd14;
    @(negedge clock);
    check("gap busy", 64'(busy), 64'd0);
    check("gap done", 64'(done), 64'd0);
    check("gap hold lo", 64'(result_lo), 64'd14);
    @(negedge clock);
    start = 1'b0;
    check("b2b illegal done", 64'(done), 64'd1);
    check("b2b illegal flag", 64'(illegal_op), 64'd1);
    check("b2b illegal lo", 64'(result_lo), 64'd0);
    check("b2b illegal hi", 64'(result_hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
